// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state/owner types and default sizes for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, CPU_OWN, CMP_OWN} arb_state_t;
  typedef enum logic {OWN_CPU, OWN_CMP} owner_t;
  localparam int DEF_MEM_DEPTH = 1024;
  localparam int DEF_MAX_BURST = 16;
endpackage

// File: rtl/dmem_arb_rr2.sv
// dmem_arb_rr2: 2-way round-robin picker; a tie goes to whoever did not win last
module dmem_arb_rr2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_cpu,
  input  logic       req_cmp,
  input  logic       upd,
  output logic [1:0] gnt
);
  owner_t last_q;
  always_comb begin
    gnt[0] = req_cpu && (!req_cmp || last_q == OWN_CMP);
    gnt[1] = req_cmp && !gnt[0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= OWN_CMP;
    else if (upd && |gnt) last_q <= gnt[0] ? OWN_CPU : OWN_CMP;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data RAM between CPU and CMP with locked CMP bursts.
// Define DMEM_ARB_PERF_CNT_EN to add saturating per-requester stall counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rd,
  input  logic              cmp_req,
  input  logic              cmp_we,
  input  logic [ADDR_W-1:0] cmp_addr,
  input  logic [DATA_W-1:0] cmp_wd,
  input  logic              cmp_last,
  output logic              cmp_gnt,
  output logic              cmp_rvalid,
  output logic [DATA_W-1:0] cmp_rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              err_oob
`ifdef DMEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       cpu_stall_cnt,
  output logic [31:0]       cmp_stall_cnt
`endif
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  arb_state_t state_q, state_d, cur;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] pick;
  logic idle, gnt, we, oob, burst_end;
  logic [ADDR_W-1:0] addr;
  logic rd_pend_q, rd_oob_q, err_q;
  owner_t rd_own_q;
  logic [DATA_W-1:0] rdata, cpu_rd_q, cmp_rd_q;
  assign idle = state_q == IDLE;
  dmem_arb_rr2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_cpu (cpu_req),
    .req_cmp (cmp_req),
    .upd     (idle),
    .gnt     (pick)
  );
  // IDLE decides and grants in the same cycle, so the owner of this cycle is combinational
  always_comb begin
    cur       = !idle ? state_q : pick[0] ? CPU_OWN : pick[1] ? CMP_OWN : IDLE;
    cpu_gnt   = cur == CPU_OWN;
    cmp_gnt   = cur == CMP_OWN && cmp_req;
    gnt       = cpu_gnt || cmp_gnt;
    addr      = cmp_gnt ? cmp_addr : cpu_addr;
    we        = cmp_gnt ? cmp_we : cpu_we;
    oob       = addr >= ADDR_W'(MEM_DEPTH);
    burst_end = cmp_gnt && (cmp_last || cnt_q + CNT_W'(1) == CNT_W'(MAX_BURST));
    state_d   = cur == CMP_OWN && !burst_end ? CMP_OWN : IDLE;
    cnt_d     = burst_end ? '0 : cmp_gnt ? cnt_q + CNT_W'(1) : cnt_q;
    mem_we    = gnt && we && !oob;
    mem_addr  = gnt ? addr : '0;
    mem_wd    = !gnt ? '0 : cmp_gnt ? cmp_wd : cpu_wd;
  end
  always_comb begin
    rdata      = rd_oob_q ? '0 : mem_rd;
    cpu_rvalid = rd_pend_q && rd_own_q == OWN_CPU;
    cmp_rvalid = rd_pend_q && rd_own_q == OWN_CMP;
    cpu_rd     = cpu_rvalid ? rdata : cpu_rd_q;
    cmp_rd     = cmp_rvalid ? rdata : cmp_rd_q;
    err_oob    = err_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_oob_q  <= 1'b0;
      rd_own_q  <= OWN_CPU;
      err_q     <= 1'b0;
      cpu_rd_q  <= '0;
      cmp_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= gnt && !we;
      rd_oob_q  <= oob;
      rd_own_q  <= cmp_gnt ? OWN_CMP : OWN_CPU;
      err_q     <= gnt && oob;
      if (cpu_rvalid) cpu_rd_q <= rdata;
      if (cmp_rvalid) cmp_rd_q <= rdata;
    end
  end
`ifdef DMEM_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_stall_cnt <= '0;
      cmp_stall_cnt <= '0;
    end else begin
      if (cpu_req && !cpu_gnt && !(&cpu_stall_cnt)) cpu_stall_cnt <= cpu_stall_cnt + 32'd1;
      if (cmp_req && !cmp_gnt && !(&cmp_stall_cnt)) cmp_stall_cnt <= cmp_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scenario tasks plus a read-return scoreboard against a synchronous RAM model
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, cmp_req = 1'b0, cmp_we = 1'b0, cmp_last = 1'b0;
  logic [AW-1:0] cpu_addr = '0, cmp_addr = '0;
  logic [DW-1:0] cpu_wd = '0, cmp_wd = '0;
  logic cpu_gnt, cpu_rvalid, cmp_gnt, cmp_rvalid, mem_we, err_oob;
  logic [DW-1:0] cpu_rd, cmp_rd, mem_wd, mem_rd;
  logic [AW-1:0] mem_addr;
`ifdef DMEM_ARB_PERF_CNT_EN
  logic [31:0] cpu_stall_cnt, cmp_stall_cnt;
`endif
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] ref_mem [1024];
  logic ram_init = 1'b0;
  typedef struct {
    logic          is_cmp;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  dmem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wd     (cpu_wd),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rd     (cpu_rd),
    .cmp_req    (cmp_req),
    .cmp_we     (cmp_we),
    .cmp_addr   (cmp_addr),
    .cmp_wd     (cmp_wd),
    .cmp_last   (cmp_last),
    .cmp_gnt    (cmp_gnt),
    .cmp_rvalid (cmp_rvalid),
    .cmp_rd     (cmp_rd),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd),
    .err_oob    (err_oob)
`ifdef DMEM_ARB_PERF_CNT_EN
    ,
    .cpu_stall_cnt (cpu_stall_cnt),
    .cmp_stall_cnt (cmp_stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'hA500_0000 | DW'(i);
      ram_init <= 1'b1;
    end else if (mem_we) ram[mem_addr[9:0]] <= mem_wd;
    mem_rd <= ram[mem_addr[9:0]];
  end

  // read-return scoreboard: each granted read must come back exactly one cycle later
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      checks++;
      if ((e.is_cmp ? cmp_rvalid : cpu_rvalid) !== 1'b1 || (e.is_cmp ? cpu_rvalid : cmp_rvalid) !== 1'b0 ||
          (e.is_cmp ? cmp_rd : cpu_rd) !== e.data) begin
        failures++;
        $display("FAIL rdata cyc=%0d owner_cmp=%b got cpu_rvalid=%b cmp_rvalid=%b cpu_rd=%h cmp_rd=%h exp data=%h",
                 cyc, e.is_cmp, cpu_rvalid, cmp_rvalid, cpu_rd, cmp_rd, e.data);
      end
    end else begin
      checks++;
      if (cpu_rvalid !== 1'b0 || cmp_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL spurious_rvalid cyc=%0d got cpu_rvalid=%b cmp_rvalid=%b exp 0 0", cyc, cpu_rvalid, cmp_rvalid);
      end
    end
  end

  function automatic void expect_rd(input logic is_cmp, input logic [AW-1:0] a);
    exp_t x;
    x.is_cmp = is_cmp;
    x.data   = a < 1024 ? ref_mem[a[9:0]] : '0;
    x.due    = cyc + 1;
    sb.push_back(x);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    cpu_req = 1'b0;
    cmp_req = 1'b0;
    cmp_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wd = d;
    @(negedge clk);
    while (cpu_gnt !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cpu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL cpu_gnt_timeout got cpu_gnt=%b exp 1 within 50 cycles", cpu_gnt);
    end else if (we) begin
      if (a < 1024) ref_mem[a[9:0]] = d;
    end else expect_rd(1'b0, a);
    @(posedge clk);
    #1 cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_gnt, cmp_gnt, cpu_rvalid, cmp_rvalid, err_oob, mem_we} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got gnt=%b%b rvalid=%b%b err=%b we=%b exp all 0",
               cpu_gnt, cmp_gnt, cpu_rvalid, cmp_rvalid, err_oob, mem_we);
    end
    checks++;
    if (cpu_rd !== '0 || cmp_rd !== '0 || mem_addr !== '0) begin
      failures++;
      $display("FAIL reset_data got cpu_rd=%h cmp_rd=%h mem_addr=%h exp 0", cpu_rd, cmp_rd, mem_addr);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_tie();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5;
    cmp_req = 1'b1; cmp_we = 1'b0; cmp_addr = 6; cmp_last = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, cmp_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL tie_first got cpu=%b cmp=%b exp cpu=1 cmp=0", cpu_gnt, cmp_gnt);
    end
    if (cpu_gnt) expect_rd(1'b0, 5);
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, cmp_gnt} !== 2'b01) begin
      failures++;
      $display("FAIL tie_second got cpu=%b cmp=%b exp cpu=0 cmp=1", cpu_gnt, cmp_gnt);
    end
    if (cmp_gnt) expect_rd(1'b1, 6);
    @(posedge clk);
    #1 cpu_req = 1'b1; cmp_addr = 7; cmp_last = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, cmp_gnt} !== 2'b01) begin
      failures++;
      $display("FAIL lock_held got cpu=%b cmp=%b exp cpu=0 cmp=1", cpu_gnt, cmp_gnt);
    end
    if (cmp_gnt) expect_rd(1'b1, 7);
    @(posedge clk);
    #1 cmp_req = 1'b0; cmp_last = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, cmp_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL lock_released got cpu=%b cmp=%b exp cpu=1 cmp=0", cpu_gnt, cmp_gnt);
    end
    if (cpu_gnt) expect_rd(1'b0, 5);
    @(posedge clk);
    #1 cpu_req = 1'b0;
  endtask

  task automatic test_rw();
    cpu_op(1'b1, 12, 32'hDEAD_BEEF);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rw_gnt got cpu_gnt=%b exp 1", cpu_gnt);
    end
    expect_rd(1'b0, 12);
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b1 || cmp_rvalid !== 1'b0 || cpu_rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rw_return got cpu_rvalid=%b cmp_rvalid=%b cpu_rd=%h exp 1 0 deadbeef", cpu_rvalid, cmp_rvalid, cpu_rd);
    end
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rw_hold got cpu_rvalid=%b cpu_rd=%h exp 0 deadbeef", cpu_rvalid, cpu_rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_forced_release();
    int beat = 0;
    logic ec, ep, cg;
    cmp_req = 1'b1; cmp_we = 1'b0; cmp_addr = 100; cmp_last = 1'b0;
    for (int c = 1; c <= 40 && beat < 20; c++) begin
      if (c == 2) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7;
      end
      @(negedge clk);
      ec = (c <= 16) || (c >= 18 && c <= 21);
      ep = (c == 17);
      checks++;
      if ({cpu_gnt, cmp_gnt} !== {ep, ec}) begin
        failures++;
        $display("FAIL burst_gnt c=%0d got cpu=%b cmp=%b exp cpu=%b cmp=%b", c, cpu_gnt, cmp_gnt, ep, ec);
      end
      cg = cpu_gnt;
      if (cmp_gnt) begin
        expect_rd(1'b1, cmp_addr);
        beat++;
      end
      if (cpu_gnt) expect_rd(1'b0, cpu_addr);
      @(posedge clk);
      #1;
      if (cg) cpu_req = 1'b0;
      cmp_addr = 100 + AW'(beat);
      cmp_last = beat == 19;
      if (beat == 20) cmp_req = 1'b0;
    end
    cmp_req = 1'b0; cmp_last = 1'b0; cpu_req = 1'b0;
    checks++;
    if (beat != 20) begin
      failures++;
      $display("FAIL burst_beats got %0d exp 20", beat);
    end
  endtask

  task automatic test_oob();
    cmp_req = 1'b1; cmp_we = 1'b1; cmp_addr = 1024; cmp_wd = 32'h1234_5678; cmp_last = 1'b1;
    @(negedge clk);
    checks++;
    if (cmp_gnt !== 1'b1 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL oob_wr_gnt got cmp_gnt=%b mem_we=%b exp 1 0", cmp_gnt, mem_we);
    end
    @(posedge clk);
    #1 cmp_req = 1'b0; cmp_we = 1'b0;
    @(negedge clk);
    checks++;
    if (err_oob !== 1'b1 || ram[0] !== ref_mem[0]) begin
      failures++;
      $display("FAIL oob_wr_err got err_oob=%b ram0=%h exp 1 %h", err_oob, ram[0], ref_mem[0]);
    end
    @(posedge clk);
    #1 cmp_req = 1'b1; cmp_addr = 2000; cmp_last = 1'b1;
    @(negedge clk);
    checks++;
    if (cmp_gnt !== 1'b1 || err_oob !== 1'b0) begin
      failures++;
      $display("FAIL oob_rd_gnt got cmp_gnt=%b err_oob=%b exp 1 0", cmp_gnt, err_oob);
    end
    if (cmp_gnt) expect_rd(1'b1, 2000);
    @(posedge clk);
    #1 cmp_req = 1'b0; cmp_last = 1'b0;
    @(negedge clk);
    checks++;
    if (err_oob !== 1'b1 || cmp_rd !== '0) begin
      failures++;
      $display("FAIL oob_rd_err got err_oob=%b cmp_rd=%h exp 1 0", err_oob, cmp_rd);
    end
    @(negedge clk);
    checks++;
    if (err_oob !== 1'b0) begin
      failures++;
      $display("FAIL oob_pulse got err_oob=%b exp 0", err_oob);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_burst();
    cmp_req = 1'b1; cmp_we = 1'b0; cmp_addr = 200; cmp_last = 1'b0;
    for (int b = 1; b <= 3; b++) begin
      @(negedge clk);
      checks++;
      if (cmp_gnt !== 1'b1) begin
        failures++;
        $display("FAIL midrst_beat b=%0d got cmp_gnt=%b exp 1", b, cmp_gnt);
      end
      if (b < 3) expect_rd(1'b1, cmp_addr);
      else rst_n = 1'b0;
      @(posedge clk);
      #1 cmp_addr = cmp_addr + 1;
    end
    cmp_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cmp_rvalid !== 1'b0 || cpu_rvalid !== 1'b0 || cmp_rd !== '0) begin
      failures++;
      $display("FAIL midrst_drop got cmp_rvalid=%b cpu_rvalid=%b cmp_rd=%h exp 0 0 0", cmp_rvalid, cpu_rvalid, cmp_rd);
    end
    @(posedge clk);
    #1 rst_n = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL midrst_cpu got cpu_gnt=%b exp 1", cpu_gnt);
    end
    if (cpu_gnt) expect_rd(1'b0, 12);
    @(posedge clk);
    #1 cpu_req = 1'b0;
  endtask

`ifdef DMEM_ARB_PERF_CNT_EN
  task automatic test_perf();
    int n = 0;
    do_reset();
    cpu_op(1'b0, 1, '0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 2;
    cmp_req = 1'b1; cmp_we = 1'b0; cmp_addr = 300; cmp_last = 1'b0;
    @(negedge clk);
    while (cpu_gnt !== 1'b1 && n < 40) begin
      if (cmp_gnt) expect_rd(1'b1, cmp_addr);
      @(posedge clk);
      #1 cmp_addr = cmp_addr + 1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (cpu_gnt !== 1'b1 || cpu_stall_cnt !== 32'd16 || cmp_stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL perf_cnt got cpu_gnt=%b cpu_stall=%0d cmp_stall=%0d exp 1 16 0", cpu_gnt, cpu_stall_cnt, cmp_stall_cnt);
    end
    if (cpu_gnt) expect_rd(1'b0, 2);
    @(posedge clk);
    #1 cpu_req = 1'b0; cmp_req = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hA500_0000 | DW'(i);
    do_reset();
    test_reset();
    test_tie();
    test_rw();
    test_forced_release();
    test_oob();
    test_reset_mid_burst();
`ifdef DMEM_ARB_PERF_CNT_EN
    test_perf();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got %0d pending reads exp 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the processor load/store port (CPU) and the compressor/decompressor streaming engine (CMP).
- Sits between both requesters and the data RAM.
- Accepts one access per cycle, gives CMP locked bursts, applies round-robin on contention and returns read data one cycle after grant.
- Rejects addresses outside the data-memory window.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 32, address bus width.
- MEM_DEPTH, 1024, data window is addresses 0..MEM_DEPTH-1.
- MAX_BURST, 16, maximum CMP beats per lock before forced release (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- cpu_req  in  1  CPU access request, held until cpu_gnt.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wd  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rd  out  DATA_W  CPU read data.
- cmp_req  in  1  CMP beat request, held until cmp_gnt.
- cmp_we  in  1  CMP write enable.
- cmp_addr  in  ADDR_W  CMP address.
- cmp_wd  in  DATA_W  CMP write data.
- cmp_last  in  1  current CMP beat ends the burst.
- cmp_gnt  out  1  CMP beat accepted.
- cmp_rvalid  out  1  CMP read data valid.
- cmp_rd  out  DATA_W  CMP read data.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wd  out  DATA_W  RAM write data.
- mem_rd  in  DATA_W  RAM read data, valid cycle after address (synchronous RAM).
- err_oob  out  1  one-cycle pulse: out-of-window access completed.

Behaviour:
- Reset (rst_n=0 at edge):
  - FSM goes to IDLE; all gnt, rvalid, err_oob and mem_we are 0; rd outputs are 0; burst counter is 0.
  - last_winner = CMP, so the CPU wins the first tie.
  - Reset mid-burst drops the lock and discards any in-flight read; no rvalid is produced for it.
- FSM states and transitions:
  - IDLE → CPU_OWN when only cpu_req; → CMP_OWN when only cmp_req; on tie, the requester that is not last_winner goes.
  - CPU_OWN: single-beat ownership. It exists only for the grant cycle, then returns to IDLE. last_winner becomes CPU.
  - CMP_OWN: lock held across beats while cmp_req is high. The CPU is stalled (cpu_gnt=0).
  - CMP_OWN exits to IDLE on a granted beat with cmp_last=1, or after the MAX_BURST-th granted beat (forced release). On exit, last_winner becomes CMP.
  - CMP_OWN with cmp_req low for a cycle: lock retained, no access issued, counter unchanged.
- Grant is combinational from current state and requests.
  - A granted cycle drives mem_addr/mem_wd/mem_we from the winner.
  - With no grant: mem_we=0, mem_addr=0.
  - Granted back-to-back: IDLE grants in the same cycle as it decides. CMP_OWN grants every cycle cmp_req is high, so throughput is 1 beat/cycle.
- Read return:
  - A registered owner tag routes mem_rd one cycle after a granted read.
  - Only the owner's rvalid pulses for one cycle; the owner's rd holds its last value until the next rvalid.
  - Write grants produce no rvalid.
- Out of range (addr >= MEM_DEPTH):
  - Grant proceeds normally, but mem_we is forced to 0.
  - A read returns 0 with rvalid.
  - err_oob pulses in the cycle after grant, for both reads and writes.
- Burst counter width is clog2(MAX_BURST+1). It resets to 0 on entry to CMP_OWN and never wraps.

Optional Feature:
- Macro: DMEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs cpu_stall_cnt[31:0] and cmp_stall_cnt[31:0].
  - Each counts cycles where that requester's req=1 and gnt=0.
  - Counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: the ports are absent and there is no counter logic; all other behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, CPU_OWN, CMP_OWN}
  - typedef enum owner_t {OWN_CPU, OWN_CMP}
  - default MEM_DEPTH and MAX_BURST constants
- One sub-module, dmem_arb_rr2: a 2-way round-robin picker holding last_winner. Inputs are the two requests and an update strobe; outputs are one-hot grants.

Test Plan:
- Reset then cpu_req=1, cmp_req=1 same cycle → cpu_gnt=1 first; next cycle cmp_gnt=1 and CMP_OWN entered.
- CPU read of addr 12 after a CPU write of 32'hDEAD_BEEF to 12 → cpu_rvalid exactly 1 cycle after gnt with cpu_rd=32'hDEAD_BEEF; cmp_rvalid stays 0.
- CMP burst of 20 beats, no cmp_last, cpu_req held → forced release after beat 16; cpu_gnt next cycle; CMP resumes after.
- CMP write to addr 1024 → mem_we=0 and err_oob=1 the following cycle; RAM contents unchanged. CMP read to 2000 → cmp_rd=0 and err_oob=1.
- rst_n low during beat 3 of a CMP read burst → no rvalid next cycle; FSM in IDLE; a subsequent cpu_req is granted immediately.
- DMEM_ARB_PERF_CNT_EN defined, CPU stalled 16 cycles behind a CMP burst → cpu_stall_cnt=16.
